histogram_cdf_generator: RTL and testbench
==========================================

HISTOGRAM_CDF_GENERATOR -- requirements
Module: histogram_cdf_generator

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 320, pixels per line.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 240, lines per image.
REQ-003 SHALL have parameter PIXEL_WIDTH, default 8, pixel bits; bin count NBINS = 2^PIXEL_WIDTH.
REQ-004 SHALL have parameter HISTOGRAM_RAM_DATA_WIDTH, default $clog2(IMAGE_WIDTH*IMAGE_HEIGHT), bits per bin and per CDF entry.
REQ-005 SHALL have parameter IMAGE_RAM_ADDRESS_WIDTH, default $clog2(IMAGE_WIDTH*IMAGE_HEIGHT), image RAM address bits.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset; one clock, reset synchronous and active-high.
REQ-007 SHALL have ports: image_generated in 1 decoded image complete (level); stop in 1 abort; is_image_RAM_available in 1 image RAM grant.
REQ-008 SHALL have ports: image_RAM_CE out 1; image_RAM_address out IMAGE_RAM_ADDRESS_WIDTH; image_RAM_data_input in PIXEL_WIDTH.
REQ-009 SHALL have ports: histogram_RAM_CE out 1; histogram_RAM_WE out 1; histogram_RAM_address out PIXEL_WIDTH; histogram_RAM_data_output out HISTOGRAM_RAM_DATA_WIDTH; histogram_RAM_data_input in HISTOGRAM_RAM_DATA_WIDTH.
REQ-010 SHALL have ports: CDF_RAM_WE out 1; CDF_RAM_address out PIXEL_WIDTH; CDF_RAM_data_output out HISTOGRAM_RAM_DATA_WIDTH.
REQ-011 SHALL have ports: histogram_generated out 1; CDF_generated out 1; CDF_min out HISTOGRAM_RAM_DATA_WIDTH; is_histogram_RAM_available out 1.
REQ-012 SHALL treat all RAMs as synchronous, read data valid the cycle after CE with address, write on clock edge with CE&WE.

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, PIX_RD, HIST_RD, HIST_WR, CDF_RD, CDF_WR, DONE.
REQ-014 SHALL leave IDLE for CLEAR when image_generated=1.
REQ-015 CLEAR: SHALL write 0 to histogram bins 0..NBINS-1, one per cycle (NBINS cycles), then enter PIX_RD with pixel index 0.
REQ-016 PIX_RD: SHALL assert image_RAM_CE with address = pixel index only when is_image_RAM_available=1, else hold in PIX_RD with CE=0.
REQ-017 HIST_RD: SHALL register image_RAM_data_input as bin and issue histogram read at that bin.
REQ-018 HIST_WR: SHALL write histogram_RAM_data_input+1 to the registered bin, saturating at all-ones; then PIX_RD for next index, or CDF_RD after index IMAGE_WIDTH*IMAGE_HEIGHT-1.
REQ-019 SHALL never overlap read-modify-write of consecutive pixels; equal consecutive pixels SHALL count exactly.
REQ-020 Unstalled accumulation SHALL take exactly 3*IMAGE_WIDTH*IMAGE_HEIGHT cycles.
REQ-021 histogram_generated SHALL rise in the cycle CDF_RD is first entered and hold until IDLE.
REQ-022 CDF_RD/CDF_WR: for bin b = 0..NBINS-1, SHALL read histogram[b], then write CDF_RAM[b] = acc + histogram[b] (saturating), acc <= that sum; acc = 0 at entry; 2 cycles per bin.
REQ-023 CDF_min SHALL capture the first nonzero CDF value written and not change afterwards until IDLE.
REQ-024 After bin NBINS-1 is written, SHALL enter DONE and assert CDF_generated.
REQ-025 is_histogram_RAM_available SHALL be 1 only in DONE; histogram_RAM_CE/WE SHALL be 0 in DONE and IDLE.
REQ-026 DONE SHALL hold while image_generated=1; on image_generated=0, SHALL return to IDLE, clearing both flags and CDF_min.
REQ-027 stop=1 in any state SHALL force IDLE next cycle with flags cleared; stop takes priority over image_generated.
REQ-028 All RAM enables SHALL be 0 in IDLE.

Reset
REQ-029 rst=1 SHALL force IDLE; histogram_generated, CDF_generated, CDF_min, acc, indices, all CE/WE = 0; is_histogram_RAM_available = 0.
REQ-030 rst mid-operation SHALL abandon the pass; the next pass SHALL restart with CLEAR.

Verification (IMAGE_WIDTH=8, IMAGE_HEIGHT=4, HISTOGRAM_RAM_DATA_WIDTH=6 unless noted)
REQ-031 All 32 pixels = 5 -> hist[5]=32, others 0; CDF[0..4]=0, CDF[5..255]=32; CDF_min=32; CDF_generated at 256+96+512 cycles after start.
REQ-032 Pixels 0..31 ramp -> hist[k]=1 for k<32; CDF[k]=k+1 for k<32, 32 above; CDF_min=1.
REQ-033 Pattern 200,200,7 repeated -> hist[200] and hist[7] match exact counts, confirming no RMW hazard.
REQ-034 is_image_RAM_available low 10 cycles mid-accumulate -> no image CE during stall; results identical; done 10 cycles later.
REQ-035 rst or stop at pixel 12, then image_generated held -> flags drop to 0; fresh pass gives correct histogram, no stale counts.
REQ-036 HISTOGRAM_RAM_DATA_WIDTH=5, all 32 pixels = 9 -> hist[9]=31 saturated, CDF[9..255]=31, CDF_min=31.

Source files
------------

// File: rtl/histogram_cdf_generator.sv
// histogram_cdf_generator
// Builds a pixel-value histogram of one decoded image and then its cumulative
// distribution (CDF). All RAMs are external and synchronous: read data is
// valid the cycle after CE with the address, and writes happen on the clock
// edge with CE&WE.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   image_generated           level: a decoded image is ready in image RAM
//   stop                      abort the current pass (returns to IDLE)
//   is_image_RAM_available    image RAM grant; pixel reads stall while low
//   image_RAM_*               pixel read port (CE, address, read data)
//   histogram_RAM_*           histogram bin RAM (CE, WE, address, wr/rd data)
//   CDF_RAM_*                 CDF write port (WE, address, write data)
//   histogram_generated       histogram complete (set on entering the CDF phase)
//   CDF_generated             CDF complete, held in DONE
//   CDF_min                   first nonzero CDF value
//   is_histogram_RAM_available  histogram RAM released to other users (DONE)
module histogram_cdf_generator #(
  parameter int IMAGE_WIDTH              = 320,
  parameter int IMAGE_HEIGHT             = 240,
  parameter int PIXEL_WIDTH              = 8,
  parameter int HISTOGRAM_RAM_DATA_WIDTH = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT),
  parameter int IMAGE_RAM_ADDRESS_WIDTH  = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                image_generated,
  input  logic                                stop,
  input  logic                                is_image_RAM_available,
  output logic                                image_RAM_CE,
  output logic [IMAGE_RAM_ADDRESS_WIDTH-1:0]  image_RAM_address,
  input  logic [PIXEL_WIDTH-1:0]              image_RAM_data_input,
  output logic                                histogram_RAM_CE,
  output logic                                histogram_RAM_WE,
  output logic [PIXEL_WIDTH-1:0]              histogram_RAM_address,
  output logic [HISTOGRAM_RAM_DATA_WIDTH-1:0] histogram_RAM_data_output,
  input  logic [HISTOGRAM_RAM_DATA_WIDTH-1:0] histogram_RAM_data_input,
  output logic                                CDF_RAM_WE,
  output logic [PIXEL_WIDTH-1:0]              CDF_RAM_address,
  output logic [HISTOGRAM_RAM_DATA_WIDTH-1:0] CDF_RAM_data_output,
  output logic                                histogram_generated,
  output logic                                CDF_generated,
  output logic [HISTOGRAM_RAM_DATA_WIDTH-1:0] CDF_min,
  output logic                                is_histogram_RAM_available
);

  localparam int HW   = HISTOGRAM_RAM_DATA_WIDTH;
  localparam int PW   = PIXEL_WIDTH;
  localparam int AW   = IMAGE_RAM_ADDRESS_WIDTH;
  localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, PIX_RD, HIST_RD, HIST_WR, CDF_RD, CDF_WR, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   bin_q, bin_d;
  logic [AW-1:0]   pix_q, pix_d;
  logic [HW-1:0]   acc_q, acc_d;
  logic [HW-1:0]   min_q, min_d;
  logic            hgen_q, hgen_d;
  logic            cgen_q, cgen_d;
  logic [HW-1:0]   cdf_sum;

  function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] x);
    if (x == {HW{1'b1}}) return x;
    return x + 1'b1;
  endfunction

  function automatic logic [HW-1:0] sat_add(input logic [HW-1:0] a,
                                            input logic [HW-1:0] b);
    logic [HW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[HW]) return {HW{1'b1}};
    return s[HW-1:0];
  endfunction

  assign cdf_sum = sat_add(acc_q, histogram_RAM_data_input);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    pix_d   = pix_q;
    acc_d   = acc_q;
    min_d   = min_q;
    hgen_d  = hgen_q;
    cgen_d  = cgen_q;

    image_RAM_CE               = 1'b0;
    image_RAM_address          = pix_q;
    histogram_RAM_CE           = 1'b0;
    histogram_RAM_WE           = 1'b0;
    histogram_RAM_address      = bin_q;
    histogram_RAM_data_output  = '0;
    CDF_RAM_WE                 = 1'b0;
    CDF_RAM_address            = bin_q;
    CDF_RAM_data_output        = cdf_sum;
    is_histogram_RAM_available = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (image_generated) begin
          state_d = CLEAR;
          bin_d   = '0;
          pix_d   = '0;
          acc_d   = '0;
        end
      end
      CLEAR: begin
        histogram_RAM_CE = 1'b1;
        histogram_RAM_WE = 1'b1;
        bin_d            = bin_q + 1'b1;
        if (bin_q == {PW{1'b1}}) begin
          state_d = PIX_RD;
          pix_d   = '0;
        end
      end
      PIX_RD: begin
        if (is_image_RAM_available) begin
          image_RAM_CE = 1'b1;
          state_d      = HIST_RD;
        end
      end
      HIST_RD: begin
        // Pixel value arrives now; it is both the bin to remember for the
        // write-back and the address of the histogram read.
        bin_d                 = image_RAM_data_input;
        histogram_RAM_CE      = 1'b1;
        histogram_RAM_address = image_RAM_data_input;
        state_d               = HIST_WR;
      end
      HIST_WR: begin
        // Write-back completes before the next pixel is even fetched, so
        // repeated values always see the freshly written count.
        histogram_RAM_CE          = 1'b1;
        histogram_RAM_WE          = 1'b1;
        histogram_RAM_data_output = sat_inc(histogram_RAM_data_input);
        if (pix_q == LAST_PIX) begin
          state_d = CDF_RD;
          bin_d   = '0;
          acc_d   = '0;
          hgen_d  = 1'b1;
        end else begin
          pix_d   = pix_q + 1'b1;
          state_d = PIX_RD;
        end
      end
      CDF_RD: begin
        histogram_RAM_CE = 1'b1;
        state_d          = CDF_WR;
      end
      CDF_WR: begin
        CDF_RAM_WE = 1'b1;
        acc_d      = cdf_sum;
        // The CDF never decreases, so an all-zero CDF_min means no nonzero
        // value has been written yet in this pass.
        if ((min_q == '0) && (cdf_sum != '0)) min_d = cdf_sum;
        bin_d = bin_q + 1'b1;
        if (bin_q == {PW{1'b1}}) begin
          state_d = DONE;
          cgen_d  = 1'b1;
        end else begin
          state_d = CDF_RD;
        end
      end
      DONE: begin
        is_histogram_RAM_available = 1'b1;
        if (!image_generated) begin
          state_d = IDLE;
          hgen_d  = 1'b0;
          cgen_d  = 1'b0;
          min_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop) begin
      state_d = IDLE;
      hgen_d  = 1'b0;
      cgen_d  = 1'b0;
      min_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      pix_q   <= '0;
      acc_q   <= '0;
      min_q   <= '0;
      hgen_q  <= 1'b0;
      cgen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      pix_q   <= pix_d;
      acc_q   <= acc_d;
      min_q   <= min_d;
      hgen_q  <= hgen_d;
      cgen_q  <= cgen_d;
    end
  end

  assign histogram_generated = hgen_q;
  assign CDF_generated       = cgen_q;
  assign CDF_min             = min_q;

endmodule

// File: tb/tb_histogram_cdf_generator.sv
module tb_histogram_cdf_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, image_generated = 1'b0, stop = 1'b0, avail = 1'b1;
  logic       image_RAM_CE;
  logic [4:0] image_RAM_address;
  logic [7:0] img_rd;
  logic       histogram_RAM_CE, histogram_RAM_WE;
  logic [7:0] histogram_RAM_address;
  logic [5:0] histogram_RAM_data_output, hrd;
  logic       CDF_RAM_WE;
  logic [7:0] CDF_RAM_address;
  logic [5:0] CDF_RAM_data_output;
  logic       histogram_generated, CDF_generated, is_hist_avail;
  logic [5:0] CDF_min;

  // Second instance with 5-bit counts for the saturation case
  logic       ig5 = 1'b0, stop5 = 1'b0;
  logic       ice5, hce5, hwe5, cwe5, hgen5, cgen5, havail5;
  logic [4:0] iaddr5;
  logic [7:0] img_rd5, haddr5, caddr5;
  logic [4:0] hdo5, hrd5, cdo5, min5;

  logic [7:0] img  [0:31];
  logic [5:0] hmem [0:255];
  logic [5:0] cmem [0:255];
  logic [4:0] hmem5[0:255];
  logic [4:0] cmem5[0:255];

  histogram_cdf_generator #(
    .IMAGE_WIDTH(8), .IMAGE_HEIGHT(4), .PIXEL_WIDTH(8),
    .HISTOGRAM_RAM_DATA_WIDTH(6), .IMAGE_RAM_ADDRESS_WIDTH(5)
  ) dut (
    .clk(clk), .rst(rst), .image_generated(image_generated), .stop(stop),
    .is_image_RAM_available(avail),
    .image_RAM_CE(image_RAM_CE), .image_RAM_address(image_RAM_address),
    .image_RAM_data_input(img_rd),
    .histogram_RAM_CE(histogram_RAM_CE), .histogram_RAM_WE(histogram_RAM_WE),
    .histogram_RAM_address(histogram_RAM_address),
    .histogram_RAM_data_output(histogram_RAM_data_output),
    .histogram_RAM_data_input(hrd),
    .CDF_RAM_WE(CDF_RAM_WE), .CDF_RAM_address(CDF_RAM_address),
    .CDF_RAM_data_output(CDF_RAM_data_output),
    .histogram_generated(histogram_generated), .CDF_generated(CDF_generated),
    .CDF_min(CDF_min), .is_histogram_RAM_available(is_hist_avail)
  );

  histogram_cdf_generator #(
    .IMAGE_WIDTH(8), .IMAGE_HEIGHT(4), .PIXEL_WIDTH(8),
    .HISTOGRAM_RAM_DATA_WIDTH(5), .IMAGE_RAM_ADDRESS_WIDTH(5)
  ) dut5 (
    .clk(clk), .rst(rst), .image_generated(ig5), .stop(stop5),
    .is_image_RAM_available(avail),
    .image_RAM_CE(ice5), .image_RAM_address(iaddr5), .image_RAM_data_input(img_rd5),
    .histogram_RAM_CE(hce5), .histogram_RAM_WE(hwe5), .histogram_RAM_address(haddr5),
    .histogram_RAM_data_output(hdo5), .histogram_RAM_data_input(hrd5),
    .CDF_RAM_WE(cwe5), .CDF_RAM_address(caddr5), .CDF_RAM_data_output(cdo5),
    .histogram_generated(hgen5), .CDF_generated(cgen5), .CDF_min(min5),
    .is_histogram_RAM_available(havail5)
  );

  // Synchronous RAM models
  always @(posedge clk) begin
    if (image_RAM_CE) img_rd <= img[image_RAM_address];
    if (histogram_RAM_CE) begin
      if (histogram_RAM_WE) hmem[histogram_RAM_address] <= histogram_RAM_data_output;
      else hrd <= hmem[histogram_RAM_address];
    end
    if (CDF_RAM_WE) cmem[CDF_RAM_address] <= CDF_RAM_data_output;
    if (ice5) img_rd5 <= img[iaddr5];
    if (hce5) begin
      if (hwe5) hmem5[haddr5] <= hdo5;
      else hrd5 <= hmem5[haddr5];
    end
    if (cwe5) cmem5[caddr5] <= cdo5;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard of expected CDF writes, filled when a pass is launched
  typedef struct { int addr; int data; } cdf_exp_t;
  cdf_exp_t sbq[$];
  int exp_hist[256];

  always @(negedge clk) begin : sb_mon
    cdf_exp_t e;
    if (CDF_RAM_WE) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL cdf_write_unexpected: got addr %0d data %0d, expected none",
                 CDF_RAM_address, CDF_RAM_data_output);
      end else begin
        e = sbq.pop_front();
        if (int'(CDF_RAM_address) != e.addr || int'(CDF_RAM_data_output) != e.data) begin
          errors++;
          $display("FAIL cdf_write: got addr %0d data %0d, expected addr %0d data %0d",
                   CDF_RAM_address, CDF_RAM_data_output, e.addr, e.data);
        end
      end
    end
  end

  typedef struct {
    int kind;   // 0: all 5, 1: ramp, 2: 200,200,7 repeated, 3: all 9
    int sbin; int scnt;
    int cbin; int ccnt;
    int cmin;
  } vec_t;
  vec_t tbl[4];

  task automatic load_image(input int kind);
    for (int i = 0; i < 32; i++) begin
      case (kind)
        0: img[i] = 8'd5;
        1: img[i] = 8'(i);
        2: img[i] = (i % 3 == 2) ? 8'd7 : 8'd200;
        default: img[i] = 8'd9;
      endcase
    end
  endtask

  task automatic push_expected();
    int cnt[256];
    int c;
    for (int b = 0; b < 256; b++) cnt[b] = 0;
    for (int i = 0; i < 32; i++) cnt[img[i]]++;
    c = 0;
    for (int b = 0; b < 256; b++) begin
      exp_hist[b] = (cnt[b] > 63) ? 63 : cnt[b];
      c = c + exp_hist[b];
      if (c > 63) c = 63;
      sbq.push_back('{addr: b, data: c});
    end
  endtask

  task automatic run_pass(input bit do_stall, input int exp_cycles);
    int n, n_start, n_hg, n_ce, stall_bad;
    n = 0; n_start = -1; n_hg = -1; n_ce = -1; stall_bad = 0;
    image_generated = 1'b1;
    while (n < 3000 && !CDF_generated) begin
      @(negedge clk);
      n++;
      if (n_start < 0 && histogram_RAM_WE) n_start = n;
      if (n_hg < 0 && histogram_generated) n_hg = n;
      if (do_stall) begin
        if (!avail && image_RAM_CE) stall_bad++;
        if (n_ce < 0 && n_start >= 0 && n - n_start >= 300 && image_RAM_CE) n_ce = n;
        if (n_ce >= 0 && n == n_ce + 3) avail = 1'b0;
        if (n_ce >= 0 && n == n_ce + 13) avail = 1'b1;
      end
    end
    avail = 1'b1;
    check("done_reached", int'(CDF_generated), 1);
    check("done_cycles", n - n_start, exp_cycles);
    check("hist_gen_cycle", n_hg - n_start, exp_cycles - 512);
    if (do_stall) begin
      check("stall_seen", int'(n_ce >= 0), 1);
      check("stall_no_ce", stall_bad, 0);
    end
  endtask

  task automatic final_checks(input vec_t v);
    check("done_hist_gen", int'(histogram_generated), 1);
    check("done_avail", int'(is_hist_avail), 1);
    check("done_hist_ce", int'(histogram_RAM_CE), 0);
    check("done_hist_we", int'(histogram_RAM_WE), 0);
    check("cdf_min", int'(CDF_min), v.cmin);
    check("hist_sample", int'(hmem[v.sbin]), v.scnt);
    check("cdf_sample", int'(cmem[v.cbin]), v.ccnt);
    check("cdf_top", int'(cmem[255]), 32);
    check("sb_drained", sbq.size(), 0);
    for (int b = 0; b < 256; b++) check($sformatf("hist_bin%0d", b), int'(hmem[b]), exp_hist[b]);
    repeat (3) begin
      @(negedge clk);
      check("done_hold", int'(CDF_generated), 1);
    end
  endtask

  task automatic release_image();
    image_generated = 1'b0;
    ig5 = 1'b0;
    @(negedge clk);
    check("rel_cdf_gen", int'(CDF_generated), 0);
    check("rel_hist_gen", int'(histogram_generated), 0);
    check("rel_cdf_min", int'(CDF_min), 0);
    check("rel_avail", int'(is_hist_avail), 0);
    check("rel_hist_ce", int'(histogram_RAM_CE), 0);
  endtask

  task automatic abort_at_12(input bit use_rst);
    int n;
    bit found;
    n = 0; found = 1'b0;
    image_generated = 1'b1;
    while (n < 2000 && !found) begin
      @(negedge clk);
      n++;
      if (image_RAM_CE && image_RAM_address == 5'd12) found = 1'b1;
    end
    check("abort_reach_pix12", int'(found), 1);
    if (use_rst) rst = 1'b1; else stop = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    check("abort_hist_gen", int'(histogram_generated), 0);
    check("abort_cdf_gen", int'(CDF_generated), 0);
    check("abort_cdf_min", int'(CDF_min), 0);
    check("abort_img_ce", int'(image_RAM_CE), 0);
    check("abort_hist_ce", int'(histogram_RAM_CE), 0);
  endtask

  initial begin
    tbl[0] = '{kind: 0, sbin: 5,   scnt: 32, cbin: 4,   ccnt: 0,  cmin: 32};
    tbl[1] = '{kind: 1, sbin: 17,  scnt: 1,  cbin: 10,  ccnt: 11, cmin: 1};
    tbl[2] = '{kind: 2, sbin: 200, scnt: 22, cbin: 100, ccnt: 10, cmin: 10};
    tbl[3] = '{kind: 3, sbin: 9,   scnt: 32, cbin: 8,   ccnt: 0,  cmin: 32};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_hist_gen", int'(histogram_generated), 0);
    check("rst_cdf_gen", int'(CDF_generated), 0);
    check("rst_cdf_min", int'(CDF_min), 0);
    check("rst_avail", int'(is_hist_avail), 0);
    check("rst_img_ce", int'(image_RAM_CE), 0);
    check("rst_hist_ce", int'(histogram_RAM_CE), 0);
    check("rst_hist_we", int'(histogram_RAM_WE), 0);
    check("rst_cdf_we", int'(CDF_RAM_WE), 0);

    for (int t = 0; t < 4; t++) begin
      load_image(tbl[t].kind);
      push_expected();
      if (tbl[t].kind == 3) ig5 = 1'b1;
      run_pass(1'b0, 864);
      final_checks(tbl[t]);
      if (tbl[t].kind == 3) begin
        check("sat_done", int'(cgen5), 1);
        check("sat_hist_gen", int'(hgen5), 1);
        check("sat_avail", int'(havail5), 1);
        check("sat_hist9", int'(hmem5[9]), 31);
        check("sat_cdf8", int'(cmem5[8]), 0);
        check("sat_cdf9", int'(cmem5[9]), 31);
        check("sat_cdf255", int'(cmem5[255]), 31);
        check("sat_cdf_min", int'(min5), 31);
      end
      release_image();
    end

    // Grant withdrawn for 10 cycles during accumulation
    load_image(1);
    push_expected();
    run_pass(1'b1, 874);
    final_checks(tbl[1]);
    release_image();

    // stop, then reset, at pixel 12 with image_generated held
    load_image(2);
    push_expected();
    abort_at_12(1'b0);
    run_pass(1'b0, 864);
    final_checks(tbl[2]);
    release_image();

    load_image(0);
    push_expected();
    abort_at_12(1'b1);
    run_pass(1'b0, 864);
    final_checks(tbl[0]);
    release_image();

    // stop in DONE drops the flags and outranks a held image_generated
    load_image(1);
    push_expected();
    run_pass(1'b0, 864);
    final_checks(tbl[1]);
    stop = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stop_cdf_gen", int'(CDF_generated), 0);
      check("stop_hist_gen", int'(histogram_generated), 0);
      check("stop_cdf_min", int'(CDF_min), 0);
      check("stop_hist_we", int'(histogram_RAM_WE), 0);
    end
    stop = 1'b0;
    push_expected();
    run_pass(1'b0, 864);
    final_checks(tbl[1]);
    release_image();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
